// File: rtl/random_range_sampler_pkg.sv
// Shared constants and state encoding for the random range sampler.
// The CPU I/O wrapper and the bench take their default sizes from here.
package random_range_sampler_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_MAX_TRIES = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  // The retry counter needs at least one bit, even when MAX_TRIES is 1.
  function automatic int tries_width(input int max_tries);
    return (max_tries > 1) ? $clog2(max_tries) : 1;
  endfunction

endpackage

// File: rtl/random_range_sampler_range_mask_gen.sv
// Combinational OR-smear: every bit at or below the top set bit of rng_m1
// is set, giving the smallest all-ones mask that covers rng-1.
module range_mask_gen
  import random_range_sampler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rng_m1,
  output logic [WIDTH-1:0] mask
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_smear
    assign mask[gi] = |rng_m1[WIDTH-1:gi];
  end

endmodule

// File: rtl/random_range_sampler.sv
// Draws an unbiased integer in [0, iRange) from the PRNG stream using
// mask-and-reject sampling, with a bounded number of tries and a fallback.
module random_range_sampler
  import random_range_sampler_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_TRIES = DEFAULT_MAX_TRIES
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [31:0]      iRandom,
  input  logic             iRequest,
  input  logic [WIDTH-1:0] iRange,
  output logic             oBusy,
  output logic             oValid,
  output logic [WIDTH-1:0] oValue,
  output logic             oError
);

  localparam int                 TRIES_W  = tries_width(MAX_TRIES);
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rng_q, rng_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;

  logic [WIDTH-1:0]   rng_m1;
  logic [WIDTH-1:0]   mask_gen;
  logic [WIDTH-1:0]   cand;

  assign rng_m1 = rng_q - WIDTH'(1);
  assign cand   = iRandom[WIDTH-1:0] & mask_q;

  range_mask_gen #(
    .WIDTH (WIDTH)
  ) u_mask_gen (
    .rng_m1 (rng_m1),
    .mask   (mask_gen)
  );

  if (WIDTH < 32) begin : g_unused_hi
    logic unused_rand_hi;
    assign unused_rand_hi = ^iRandom[31:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    rng_d   = rng_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    value_d = value_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iRequest) begin
          if (iRange == '0) begin
            error_d = 1'b1;
          end else begin
            rng_d   = iRange;
            tries_d = '0;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        mask_d  = mask_gen;
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (cand < rng_q) begin
          value_d = cand;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tries_q == LAST_TRY) begin
          // mask < 2*rng, so a rejected candidate minus rng is in range.
          value_d = cand - rng_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tries_d = tries_q + TRIES_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      rng_q   <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rng_q   <= rng_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      value_q <= value_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign oBusy  = (state_q == ST_SETUP) || (state_q == ST_SAMPLE);
  assign oValid = valid_q;
  assign oValue = value_q;
  assign oError = error_q;

endmodule

// File: tb/tb_random_range_sampler.sv
// Directed checks of the range sampler plus a run against a bench-side
// 32-bit Galois LFSR seeded with 0xFA114514.
module tb_random_range_sampler;
  import random_range_sampler_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic          iClock;
  logic          iReset;
  logic [31:0]   iRandom;
  logic          iRequest;
  logic [W-1:0]  iRange;
  logic          oBusy;
  logic          oValid;
  logic [W-1:0]  oValue;
  logic          oError;

  int total;
  int bad;

  random_range_sampler #(
    .WIDTH     (W),
    .MAX_TRIES (DEFAULT_MAX_TRIES)
  ) dut (
    .iClock   (iClock),
    .iReset   (iReset),
    .iRandom  (iRandom),
    .iRequest (iRequest),
    .iRange   (iRange),
    .oBusy    (oBusy),
    .oValid   (oValid),
    .oValue   (oValue),
    .oError   (oError)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input logic busy, input logic valid,
                          input logic [W-1:0] value, input logic err);
    chk({tag, ".busy"},  32'(oBusy),  32'(busy));
    chk({tag, ".valid"}, 32'(oValid), 32'(valid));
    chk({tag, ".value"}, 32'(oValue), 32'(value));
    chk({tag, ".error"}, 32'(oError), 32'(err));
  endtask

  logic [31:0] lfsr;
  int          draws;
  int          cycles;
  logic [5:0]  seen;

  initial begin
    total    = 0;
    bad      = 0;
    iReset   = 1'b1;
    iRequest = 1'b0;
    iRange   = '0;
    iRandom  = '0;
    step();
    step();
    chk_outs("reset", 1'b0, 1'b0, 16'h0, 1'b0);
    iReset = 1'b0;
    step();

    // Accept on first sample: 7 < 10.
    iRange = 16'd10; iRandom = 32'h0000_0007; iRequest = 1'b1;
    step();
    iRequest = 1'b0;
    chk_outs("acc.setup", 1'b1, 1'b0, 16'h0, 1'b0);
    step();
    chk_outs("acc.sample", 1'b1, 1'b0, 16'h0, 1'b0);
    step();
    chk_outs("acc.valid", 1'b0, 1'b1, 16'd7, 1'b0);
    step();
    chk_outs("acc.hold", 1'b0, 1'b0, 16'd7, 1'b0);

    // Always rejected (12 & 0xF = 12 >= 10): fallback 12-10 after 8 samples.
    iRange = 16'd10; iRandom = 32'h0000_000C; iRequest = 1'b1;
    step();
    iRequest = 1'b0;
    iRange   = 16'd3;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("rej.busy%0d", k),  32'(oBusy),  32'd1);
      chk($sformatf("rej.valid%0d", k), 32'(oValid), 32'd0);
    end
    step();
    chk_outs("rej.valid", 1'b0, 1'b1, 16'd2, 1'b0);

    // Zero range is rejected with a one-cycle error.
    iRange = 16'd0; iRequest = 1'b1;
    step();
    iRequest = 1'b0;
    chk_outs("err.pulse", 1'b0, 1'b0, 16'd2, 1'b1);
    step();
    chk_outs("err.clear", 1'b0, 1'b0, 16'd2, 1'b0);

    // Range of one always yields zero.
    iRange = 16'd1; iRandom = 32'hFFFF_FFFF; iRequest = 1'b1;
    step();
    iRequest = 1'b0;
    step();
    step();
    chk_outs("one.valid", 1'b0, 1'b1, 16'd0, 1'b0);

    // Power-of-two range: mask 0x7FFF, upper random bits ignored.
    iRange = 16'h8000; iRandom = 32'hABCD_1234; iRequest = 1'b1;
    step();
    iRequest = 1'b0;
    step();
    step();
    chk_outs("pow2.valid", 1'b0, 1'b1, 16'h1234, 1'b0);

    // Reset during the third sample cycle of a rejecting draw.
    iRange = 16'd10; iRandom = 32'h0000_000C; iRequest = 1'b1;
    step();
    iRequest = 1'b0;
    step();
    step();
    step();
    chk("rst.busy_pre", 32'(oBusy), 32'd1);
    iReset = 1'b1;
    step();
    iReset = 1'b0;
    chk_outs("rst.after", 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("rst.novalid%0d", k), 32'(oValid), 32'd0);
    end

    // Request held through the valid cycle starts a new draw at once.
    iRange = 16'd10; iRandom = 32'h0000_0005; iRequest = 1'b1;
    step();
    step();
    step();
    chk_outs("rereq.first", 1'b0, 1'b1, 16'd5, 1'b0);
    iRandom = 32'h0000_0003;
    step();
    iRequest = 1'b0;
    chk_outs("rereq.setup", 1'b1, 1'b0, 16'd5, 1'b0);
    step();
    step();
    chk_outs("rereq.second", 1'b0, 1'b1, 16'd3, 1'b0);
    step();

    // Back-to-back draws from the LFSR stream with range 6.
    lfsr     = 32'hFA11_4514;
    iRandom  = lfsr;
    iRange   = 16'd6;
    iRequest = 1'b1;
    draws    = 0;
    cycles   = 0;
    seen     = '0;
    while (draws < 1000 && cycles < 20000) begin
      @(posedge iClock);
      #1;
      lfsr    = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
      iRandom = lfsr;
      cycles++;
      if (oValid) begin
        total++;
        assert (oValue < 16'd6) else begin
          bad++;
          $error("FAIL lfsr.range observed=%0d expected=<6", oValue);
        end
        if (oValue < 16'd6) seen[oValue[2:0]] = 1'b1;
        draws++;
      end
    end
    iRequest = 1'b0;
    $display("lfsr draws=%0d cycles=%0d seen=%b", draws, cycles, seen);
    chk("lfsr.draws", 32'(draws), 32'd1000);
    chk("lfsr.cover", 32'(seen), 32'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
